// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: ALU result writeback, PC update and post-redirect flush; define ALU_OVF_TRAP_EN to trap on add overflow
module alu_writeback_stage #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [7:0] TRAP_VECTOR  = 8'hF0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] s,
  input  logic [7:0] f,
  input  logic       ovf,
  input  logic       take_branch,
  input  logic [2:0] dest,
  input  logic [7:0] br_offset,
  input  logic [2:0] rd_addr_a,
  input  logic [2:0] rd_addr_b,
  output logic [7:0] rd_data_a,
  output logic [7:0] rd_data_b,
  output logic [7:0] pc,
  output logic       ovf_sticky,
  input  logic       ovf_clr,
  output logic [7:0] retired
);
  typedef enum logic {ACCEPT, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      pc_q, pc_d, retired_q, retired_d;
  logic            ovf_sticky_q, ovf_sticky_d;
  logic [7:0][7:0] regs_q, regs_d;
  logic            xfer, is_br, taken, add_ovf, trap, redirect, wr_en;
  always_comb begin
    xfer     = in_valid && state_q == ACCEPT;
    is_br    = s[2:1] == 2'b11;
    taken    = is_br && take_branch;
    add_ovf  = xfer && s == 3'b000 && ovf;
`ifdef ALU_OVF_TRAP_EN
    trap     = add_ovf;
`else
    trap     = 1'b0;
`endif
    redirect = xfer && (taken || trap);
    wr_en    = xfer && !is_br && !trap && dest != 3'd0;
    pc_d     = !xfer ? pc_q : trap ? TRAP_VECTOR : taken ? pc_q + br_offset : pc_q + 8'd1;
    state_d  = redirect ? FLUSH : (state_q == FLUSH && cnt_q == 3'd0) ? ACCEPT : state_q;
    cnt_d    = redirect ? 3'(FLUSH_CYCLES - 1) : (state_q == FLUSH && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    retired_d    = retired_q + {7'd0, xfer};
    ovf_sticky_d = add_ovf ? 1'b1 : ovf_clr ? 1'b0 : ovf_sticky_q;
    regs_d = regs_q;
    if (wr_en) regs_d[dest] = f;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCEPT;
      cnt_q        <= 3'd0;
      pc_q         <= RESET_PC;
      retired_q    <= 8'd0;
      ovf_sticky_q <= 1'b0;
      regs_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
      ovf_sticky_q <= ovf_sticky_d;
      regs_q       <= regs_d;
    end
  end
  assign in_ready   = state_q == ACCEPT;
  assign rd_data_a  = rd_addr_a == 3'd0 ? 8'd0 : regs_q[rd_addr_a];
  assign rd_data_b  = rd_addr_b == 3'd0 ? 8'd0 : regs_q[rd_addr_b];
  assign pc         = pc_q;
  assign ovf_sticky = ovf_sticky_q;
  assign retired    = retired_q;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed checks of writeback, branching, flush, sticky overflow and reset
module tb_alu_writeback_stage;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, ovf, take_branch, ovf_sticky, ovf_clr;
  logic [2:0] s, dest, rd_addr_a, rd_addr_b;
  logic [7:0] f, br_offset, rd_data_a, rd_data_b, pc, retired;
  int         checks = 0;
  int         errors = 0;

  alu_writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .s(s), .f(f),
    .ovf(ovf), .take_branch(take_branch), .dest(dest), .br_offset(br_offset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pc(pc), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] res,
                       input logic o, input logic tb, input logic [2:0] d, input logic [7:0] off);
    in_valid = v; s = op; f = res; ovf = o; take_branch = tb; dest = d; br_offset = off;
  endtask

  initial begin
    rst_n = 1'b0; ovf_clr = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    step(); step();
    chk("reset_pc", pc, 8'h00);
    chk("reset_retired", retired, 8'h00);
    chk("reset_sticky", {7'd0, ovf_sticky}, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", {7'd0, in_ready}, 8'h01);

    drive(1'b1, 3'b000, 8'hB3, 1'b0, 1'b0, 3'd5, 8'h00);
    rd_addr_a = 3'd5;
    #1;
    chk("no_bypass", rd_data_a, 8'h00);
    step();
    chk("write_r5", rd_data_a, 8'hB3);
    chk("pc_inc", pc, 8'h01);
    chk("retired_1", retired, 8'h01);
    drive(1'b1, 3'b000, 8'h77, 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    rd_addr_a = 3'd0; rd_addr_b = 3'd5;
    #1;
    chk("r0_zero", rd_data_a, 8'h00);
    chk("read_b_r5", rd_data_b, 8'hB3);
    chk("pc_2", pc, 8'h02);

    drive(1'b1, 3'b110, 8'h00, 1'b0, 1'b1, 3'd0, 8'hFC);
    step();
    chk("branch_pc", pc, 8'hFE);
    chk("flush1_ready", {7'd0, in_ready}, 8'h00);
    chk("branch_retired", retired, 8'h03);
    drive(1'b1, 3'b000, 8'h11, 1'b0, 1'b0, 3'd1, 8'h00);
    step();
    chk("flush2_ready", {7'd0, in_ready}, 8'h00);
    step();
    in_valid = 1'b0;
    rd_addr_a = 3'd1;
    #1;
    chk("flush_done_ready", {7'd0, in_ready}, 8'h01);
    chk("flush_retired", retired, 8'h03);
    chk("flush_pc", pc, 8'hFE);
    chk("flush_no_write", rd_data_a, 8'h00);

    drive(1'b1, 3'b001, 8'h22, 1'b0, 1'b1, 3'd2, 8'h40);
    step();
    rd_addr_a = 3'd2;
    #1;
    chk("tb_ignored_pc", pc, 8'hFF);
    chk("write_r2", rd_data_a, 8'h22);
    drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 3'd0, 8'h40);
    step();
    chk("wrap_pc", pc, 8'h00);
    chk("nottaken_ready", {7'd0, in_ready}, 8'h01);
    chk("retired_5", retired, 8'h05);

    drive(1'b1, 3'b000, 8'hB3, 1'b1, 1'b0, 3'd3, 8'h00);
    ovf_clr = 1'b1;
    rd_addr_a = 3'd3;
    step();
    chk("sticky_set_wins", {7'd0, ovf_sticky}, 8'h01);
    chk("ovf_retired", retired, 8'h06);
`ifdef ALU_OVF_TRAP_EN
    chk("trap_r3", rd_data_a, 8'h00);
    chk("trap_pc", pc, 8'hF0);
    chk("trap_ready", {7'd0, in_ready}, 8'h00);
`else
    chk("ovf_r3", rd_data_a, 8'hB3);
    chk("ovf_pc", pc, 8'h01);
    chk("ovf_ready", {7'd0, in_ready}, 8'h01);
`endif
    in_valid = 1'b0;
    step();
    chk("sticky_clr", {7'd0, ovf_sticky}, 8'h00);
    ovf_clr = 1'b0;
    step();
    chk("post_ovf_ready", {7'd0, in_ready}, 8'h01);
    drive(1'b1, 3'b010, 8'h5A, 1'b1, 1'b0, 3'd4, 8'h00);
    rd_addr_a = 3'd4;
    step();
    in_valid = 1'b0;
    #1;
    chk("sticky_non_add", {7'd0, ovf_sticky}, 8'h00);
    chk("write_r4", rd_data_a, 8'h5A);
`ifdef ALU_OVF_TRAP_EN
    chk("pc_after_ovf", pc, 8'hF1);
`else
    chk("pc_after_ovf", pc, 8'h02);
`endif

    drive(1'b1, 3'b110, 8'h00, 1'b1, 1'b1, 3'd0, 8'h10);
    step();
    in_valid = 1'b0;
    #1;
    chk("pre_reset_flush", {7'd0, in_ready}, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("midreset_pc", pc, 8'h00);
    chk("midreset_retired", retired, 8'h00);
    chk("midreset_ready", {7'd0, in_ready}, 8'h01);
    chk("midreset_sticky", {7'd0, ovf_sticky}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1;
      chk($sformatf("midreset_r%0d", i), rd_data_a, 8'h00);
    end
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_ready", {7'd0, in_ready}, 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
